// File: rtl/door_alarm_pkg.sv
// Shared definitions for the door alarm controller: state encoding,
// default timing parameters and the Moore output decode.
package door_alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_SIREN    = 3'd3,
    ST_SILENCED = 3'd4
  } state_e;

  localparam int DEFAULT_ENTRY_DELAY = 4;
  localparam int DEFAULT_SIREN_TIME  = 6;
  localparam int DEFAULT_CNT_W       = 8;

  // Output bundle packed as {armed, pending, siren, alarm_latched}.
  function automatic logic [3:0] decode_outputs(input state_e st);
    logic [3:0] outs;
    case (st)
      ST_DISARMED: outs = 4'b0000;
      ST_ARMED:    outs = 4'b1000;
      ST_ENTRY:    outs = 4'b1100;
      ST_SIREN:    outs = 4'b1011;
      ST_SILENCED: outs = 4'b1001;
      default:     outs = 4'b0000;
    endcase
    return outs;
  endfunction

endpackage

// File: rtl/alarm_countdown.sv
// Loadable down-counter shared by the entry delay and the siren timer.
// Saturates at zero so an enabled count never wraps.
module alarm_countdown #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement while enabled and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (enable && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/door_alarm_controller.sv
// Arm/disarm security layer over the raw door alarm: entry delay on a
// door opening, a bounded siren pulse, and a latched event flag that is
// held until disarm. All outputs are registered decodes of the next state.
module door_alarm_controller
  import door_alarm_pkg::*;
#(
  parameter int ENTRY_DELAY = DEFAULT_ENTRY_DELAY,
  parameter int SIREN_TIME  = DEFAULT_SIREN_TIME,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic door_alarm,
  input  logic arm,
  input  logic disarm,
  output logic armed,
  output logic pending,
  output logic siren,
  output logic alarm_latched
);

  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

  state_e           state_q;
  state_e           state_d;
  logic             door_prev_q;
  logic [3:0]       outs_q;
  logic [3:0]       outs_d;
  logic             trig_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_load_value_s;
  logic             cnt_enable_s;
  logic             cnt_zero_s;

  alarm_countdown #(
    .CNT_W (CNT_W)
  ) u_countdown (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load_s),
    .load_value (cnt_load_value_s),
    .enable     (cnt_enable_s),
    .zero       (cnt_zero_s)
  );

  // Next-state and counter control; disarm > expiry > trigger > arm.
  always_comb begin
    trig_s           = door_alarm & ~door_prev_q;
    state_d          = state_q;
    cnt_load_s       = 1'b0;
    cnt_load_value_s = {CNT_W{1'b0}};
    cnt_enable_s     = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        // Arming with the door already open is refused.
        if (arm && !disarm && !door_alarm) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_DISARMED;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_d = ST_DISARMED;
        end else if (trig_s) begin
          state_d          = ST_ENTRY;
          cnt_load_s       = 1'b1;
          cnt_load_value_s = ENTRY_LOAD;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_ENTRY: begin
        if (disarm) begin
          state_d = ST_DISARMED;
        end else if (cnt_zero_s) begin
          state_d          = ST_SIREN;
          cnt_load_s       = 1'b1;
          cnt_load_value_s = SIREN_LOAD;
        end else begin
          cnt_enable_s = 1'b1;
        end
      end
      ST_SIREN: begin
        // A fresh trigger here does not extend the siren.
        if (disarm) begin
          state_d = ST_DISARMED;
        end else if (cnt_zero_s) begin
          state_d = ST_SILENCED;
        end else begin
          cnt_enable_s = 1'b1;
        end
      end
      ST_SILENCED: begin
        // Re-trigger goes straight to the siren without a second delay.
        if (disarm) begin
          state_d = ST_DISARMED;
        end else if (trig_s) begin
          state_d          = ST_SIREN;
          cnt_load_s       = 1'b1;
          cnt_load_value_s = SIREN_LOAD;
        end else begin
          state_d = ST_SILENCED;
        end
      end
      default: begin
        state_d = ST_DISARMED;
      end
    endcase
    outs_d = decode_outputs(state_d);
  end

  // State, door edge history and registered output decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_DISARMED;
      door_prev_q <= 1'b0;
      outs_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      door_prev_q <= door_alarm;
      outs_q      <= outs_d;
    end
  end

  assign armed         = outs_q[3];
  assign pending       = outs_q[2];
  assign siren         = outs_q[1];
  assign alarm_latched = outs_q[0];

endmodule

// File: tb/tb_door_alarm_controller.sv
// Directed, table-driven bench for door_alarm_controller with the default
// ENTRY_DELAY=4 / SIREN_TIME=6. Each record holds the inputs for one cycle
// and the outputs expected right after the following rising edge.
module tb_door_alarm_controller;

  typedef struct {
    logic       rst;
    logic       door;
    logic       arm;
    logic       dis;
    logic [3:0] exp; // {armed, pending, siren, alarm_latched}
  } vec_t;

  logic clk;
  logic reset;
  logic door_alarm;
  logic arm;
  logic disarm;
  logic armed;
  logic pending;
  logic siren;
  logic alarm_latched;

  int errors;
  int checks;
  vec_t vecs[$];

  door_alarm_controller dut (
    .clk           (clk),
    .reset         (reset),
    .door_alarm    (door_alarm),
    .arm           (arm),
    .disarm        (disarm),
    .armed         (armed),
    .pending       (pending),
    .siren         (siren),
    .alarm_latched (alarm_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic d, input logic a,
                     input logic ds, input logic [3:0] e);
    vec_t v;
    v.rst = r; v.door = d; v.arm = a; v.dis = ds; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input int idx, input logic [3:0] exp);
    logic [3:0] act;
    act = {armed, pending, siren, alarm_latched};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: outputs {armed,pending,siren,latched} got %b expected %b",
               tag, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and compare just after the edge.
  task automatic step(input string tag, input int idx, input logic r, input logic d,
                      input logic a, input logic ds, input logic [3:0] exp);
    @(negedge clk);
    reset = r; door_alarm = d; arm = a; disarm = ds;
    @(posedge clk);
    #1;
    check(tag, idx, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; door_alarm = 1'b0; arm = 1'b0; disarm = 1'b0;

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      step("reset_random", i, 1'b1, 1'(($urandom) & 1), 1'(($urandom) & 1),
           1'(($urandom) & 1), 4'b0000);
    end

    // Main scenario table.
    add(0, 0, 1, 0, 4'b1000); // arm -> armed
    add(0, 0, 0, 0, 4'b1000);
    add(0, 1, 0, 0, 4'b1100); // door rises: entry delay starts
    add(0, 1, 0, 0, 4'b1100);
    add(0, 1, 0, 0, 4'b1100);
    add(0, 1, 0, 0, 4'b1100); // 4th pending cycle
    add(0, 1, 0, 0, 4'b1011); // siren 1
    add(0, 1, 0, 0, 4'b1011); // siren 2
    add(0, 0, 0, 0, 4'b1011); // siren 3, door falls
    add(0, 1, 0, 0, 4'b1011); // siren 4, re-trigger ignored
    add(0, 1, 0, 0, 4'b1011); // siren 5
    add(0, 1, 0, 0, 4'b1011); // siren 6
    add(0, 1, 0, 0, 4'b1001); // silenced, latch held
    add(0, 1, 0, 0, 4'b1001); // door held high: no re-siren
    add(0, 0, 0, 0, 4'b1001);
    add(0, 1, 0, 0, 4'b1011); // new edge: siren immediately
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 4'b1011);
    add(0, 1, 0, 0, 4'b1001); // second siren over
    add(0, 1, 0, 1, 4'b0000); // disarm clears everything
    add(0, 1, 1, 0, 4'b0000); // arm refused with door open
    add(0, 0, 1, 1, 4'b0000); // arm+disarm together stays disarmed
    add(0, 0, 1, 0, 4'b1000);
    add(0, 1, 0, 0, 4'b1100); // trigger
    add(0, 1, 0, 1, 4'b0000); // disarm in 2nd entry cycle
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 4'b0000); // siren never comes
    add(0, 0, 1, 0, 4'b1000);
    add(0, 1, 0, 0, 4'b1100);
    add(0, 1, 1, 0, 4'b1100); // arm while armed is ignored
    add(0, 1, 0, 0, 4'b1100);
    add(0, 1, 0, 0, 4'b1100);
    add(0, 1, 0, 1, 4'b0000); // disarm beats expiry
    add(0, 0, 0, 0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step("table", i, vecs[i].rst, vecs[i].door, vecs[i].arm, vecs[i].dis, vecs[i].exp);
    end

    // Reset during the third siren cycle aborts with no residue.
    step("rst_seq_arm", 0, 0, 0, 1, 0, 4'b1000);
    step("rst_seq_trig", 1, 0, 1, 0, 0, 4'b1100);
    for (int i = 0; i < 3; i++) step("rst_seq_entry", 2 + i, 0, 1, 0, 0, 4'b1100);
    for (int i = 0; i < 3; i++) step("rst_seq_siren", 5 + i, 0, 1, 0, 0, 4'b1011);
    step("rst_seq_reset", 8, 1, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step("rst_seq_idle", 9 + i, 0, 1'(i & 1), 0, 0, 4'b0000);
    end
    step("rst_seq_rearm", 17, 0, 0, 1, 0, 4'b1000);
    step("rst_seq_retrig", 18, 0, 1, 0, 0, 4'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
